// File: rtl/free_addr_arbiter_if.sv
// Free-address handshake bundle: shared free-address offer with a one-hot
// per-port valid, per-port ready, the release path and the status outputs.
interface free_addr_arbiter_if #(
   parameter int NUM_PORTS = 16,
   parameter int ADDR_W    = 12
);
   logic [ADDR_W-1:0]    oEptyAddr;
   logic [NUM_PORTS-1:0] oEptyAddrVld;
   logic [NUM_PORTS-1:0] iEptyAddrRcvRdy;
   logic [ADDR_W-1:0]    iRlsAddr;
   logic                 iRlsVld;
   logic                 oRlsRdy;
   logic [ADDR_W:0]      oFreeCnt;
   logic                 oInitDone;

   // Arbiter side: owns the pool, offers addresses, accepts releases.
   modport master (
      output oEptyAddr, oEptyAddrVld, oRlsRdy, oFreeCnt, oInitDone,
      input  iEptyAddrRcvRdy, iRlsAddr, iRlsVld
   );

   // Client side: unpack engines and the release source.
   modport slave (
      input  oEptyAddr, oEptyAddrVld, oRlsRdy, oFreeCnt, oInitDone,
      output iEptyAddrRcvRdy, iRlsAddr, iRlsVld
   );
endinterface

// File: rtl/free_addr_arbiter.sv
// Free block-address pool: a circular FIFO of buffer addresses, filled with
// 0..DEPTH-1 after reset, handed out one at a time to round-robin-selected
// ports through a single held output stage, and refilled by releases.
module free_addr_arbiter #(
   parameter int NUM_PORTS = 16,
   parameter int ADDR_W    = 12
) (
   input  logic                iClk,
   input  logic                iRst_n,
   free_addr_arbiter_if.master bus
);
   localparam int              DEPTH    = 2 ** ADDR_W;
   localparam int              PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   logic [ADDR_W-1:0]    mem [DEPTH];
   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    rd_ptr_q, wr_ptr_q;
   logic [ADDR_W:0]      count_q, count_d;
   logic [NUM_PORTS-1:0] vld_q, vld_d;
   logic [ADDR_W-1:0]    addr_q;
   logic [PW-1:0]        last_grant_q;
   logic                 rls_rdy_q;
   logic [ADDR_W:0]      free_cnt_q;
   logic                 init_done_q;

   logic [NUM_PORTS-1:0] ready, hi_mask, req_hi;
   logic [PW-1:0]        winner, winner_hi, winner_lo;
   logic                 xfer, load, push, mem_we;
   logic [ADDR_W-1:0]    mem_wdata;

   assign ready  = bus.iEptyAddrRcvRdy;
   assign req_hi = ready & hi_mask;

   // Ports strictly above the last grant get first pick on the next load.
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
      assign hi_mask[gi] = (PW'(gi) > last_grant_q);
   end

   // Round-robin pick: lowest ready port above last grant, else lowest ready port overall.
   always_comb begin
      winner_hi = '0;
      winner_lo = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (req_hi[k]) winner_hi = PW'(k);
         if (ready[k])  winner_lo = PW'(k);
      end
      winner = (|req_hi) ? winner_hi : winner_lo;
   end

   // Handshake decode and next-state for pool occupancy, stage and FSM.
   always_comb begin
      xfer      = |(vld_q & ready);
      push      = (state_q == ST_RUN) && bus.iRlsVld && rls_rdy_q;
      load      = (state_q == ST_RUN) && (!(|vld_q) || xfer) &&
                  (count_q != '0) && (|ready);
      state_d   = state_q;
      count_d   = count_q;
      mem_we    = 1'b0;
      mem_wdata = bus.iRlsAddr;
      if (state_q == ST_INIT) begin
         // wr_ptr doubles as the init counter: mem[i] = i
         mem_we    = 1'b1;
         mem_wdata = wr_ptr_q;
         count_d   = count_q + CNT_ONE;
         if (count_d == CNT_FULL) state_d = ST_RUN;
      end else begin
         mem_we = push;
         if (push && !load)      count_d = count_q + CNT_ONE;
         else if (load && !push) count_d = count_q - CNT_ONE;
      end
      vld_d = vld_q;
      if (load) begin
         vld_d         = '0;
         vld_d[winner] = 1'b1;
      end else if (xfer) begin
         vld_d = '0;
      end
   end

   // Pool storage write port (init fill or release); read happens on load below.
   always_ff @(posedge iClk) begin
      if (mem_we) mem[wr_ptr_q] <= mem_wdata;
   end

   // FSM, pointers, output stage and registered status outputs.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q      <= ST_INIT;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         vld_q        <= '0;
         addr_q       <= '0;
         last_grant_q <= '0;
         rls_rdy_q    <= 1'b0;
         free_cnt_q   <= '0;
         init_done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         vld_q   <= vld_d;
         if (mem_we) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         if (load) begin
            addr_q       <= mem[rd_ptr_q];
            rd_ptr_q     <= rd_ptr_q + ADDR_W'(1);
            last_grant_q <= winner;
         end
         rls_rdy_q   <= (state_d == ST_RUN) && (count_d < CNT_FULL);
         free_cnt_q  <= count_d + (ADDR_W + 1)'(|vld_d);
         init_done_q <= (state_d == ST_RUN);
      end
   end

   assign bus.oEptyAddr    = addr_q;
   assign bus.oEptyAddrVld = vld_q;
   assign bus.oRlsRdy      = rls_rdy_q;
   assign bus.oFreeCnt     = free_cnt_q;
   assign bus.oInitDone    = init_done_q;
endmodule

// File: tb/tb_free_addr_arbiter.sv
// Directed bench for free_addr_arbiter: init fill, full-pool release refusal,
// single-port streaming, round-robin alternation, grant hold, drain,
// release refill, simultaneous push/pop and mid-stream reset.
module tb_free_addr_arbiter;
   localparam int NP = 16;
   localparam int AW = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   n;

   free_addr_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

   free_addr_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
      .iClk   (clk),
      .iRst_n (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic show(input string step);
      $display("%-12s vld=%04h addr=%03h free=%0d rls_rdy=%0b init_done=%0b",
               step, bus.oEptyAddrVld, bus.oEptyAddr, bus.oFreeCnt, bus.oRlsRdy, bus.oInitDone);
   endtask

   initial begin
      bus.iEptyAddrRcvRdy = '0;
      bus.iRlsVld         = 1'b0;
      bus.iRlsAddr        = '0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      show("reset");
      chk("rst_vld",       32'(bus.oEptyAddrVld), 0);
      chk("rst_addr",      32'(bus.oEptyAddr),    0);
      chk("rst_rlsrdy",    32'(bus.oRlsRdy),      0);
      chk("rst_free",      32'(bus.oFreeCnt),     0);
      chk("rst_initdone",  32'(bus.oInitDone),    0);
      rst_n = 1'b1;

      // Init fill: exactly DEPTH edges, pool full so releases are refused
      n = 0;
      while (!bus.oInitDone && n < 5000) begin
         tick();
         n++;
      end
      show("init_done");
      chk("init_edges",  32'(n), 4096);
      chk("init_free",   32'(bus.oFreeCnt), 4096);
      chk("init_rlsrdy", 32'(bus.oRlsRdy),  0);
      chk("init_vld",    32'(bus.oEptyAddrVld), 0);

      // Full pool: release request ignored
      bus.iRlsVld  = 1'b1;
      bus.iRlsAddr = 12'hABC;
      repeat (3) begin
         tick();
         show("full_rls");
         chk("full_rlsrdy", 32'(bus.oRlsRdy),  0);
         chk("full_free",   32'(bus.oFreeCnt), 4096);
      end
      bus.iRlsVld = 1'b0;

      // Port 3 alone: addresses 0,1,2,3 on consecutive edges
      bus.iEptyAddrRcvRdy = 16'h0008;
      for (int i = 0; i < 4; i++) begin
         tick();
         show("p3_grant");
         chk("p3_vld",  32'(bus.oEptyAddrVld), 32'h0008);
         chk("p3_addr", 32'(bus.oEptyAddr),    i);
         chk("p3_free", 32'(bus.oFreeCnt),     4096 - i);
      end
      chk("p3_rlsrdy", 32'(bus.oRlsRdy), 1);
      bus.iEptyAddrRcvRdy = 16'h0000;
      tick();
      show("p3_hold");
      chk("p3_hold_vld",  32'(bus.oEptyAddrVld), 32'h0008);
      chk("p3_hold_addr", 32'(bus.oEptyAddr),    3);
      chk("p3_hold_free", 32'(bus.oFreeCnt),     4093);

      // Port 3 takes its held address while 0 and 5 join; then 0/5 alternate
      bus.iEptyAddrRcvRdy = 16'h0029;
      tick();
      show("rr_grant");
      chk("rr_vld0",  32'(bus.oEptyAddrVld), 32'h0020);
      chk("rr_addr0", 32'(bus.oEptyAddr),    4);
      chk("rr_free0", 32'(bus.oFreeCnt),     4092);
      bus.iEptyAddrRcvRdy = 16'h0021;
      for (int i = 1; i <= 4; i++) begin
         tick();
         show("rr_grant");
         chk("rr_vld",  32'(bus.oEptyAddrVld), (i % 2 == 1) ? 32'h0001 : 32'h0020);
         chk("rr_addr", 32'(bus.oEptyAddr),    4 + i);
         chk("rr_free", 32'(bus.oFreeCnt),     4092 - i);
      end

      // Port 5 drops ready while holding a grant: no move, no re-arbitration
      bus.iEptyAddrRcvRdy = 16'h0001;
      repeat (2) begin
         tick();
         show("p5_hold");
         chk("p5_hold_vld",  32'(bus.oEptyAddrVld), 32'h0020);
         chk("p5_hold_addr", 32'(bus.oEptyAddr),    8);
         chk("p5_hold_free", 32'(bus.oFreeCnt),     4088);
      end

      // Drain remaining 4087 addresses round-robin across all ports
      bus.iEptyAddrRcvRdy = 16'hFFFF;
      for (int i = 0; i < 4087; i++) begin
         tick();
         chk("drain_addr", 32'(bus.oEptyAddr),    9 + i);
         chk("drain_vld",  32'(bus.oEptyAddrVld), 1 << ((6 + i) % 16));
      end
      show("drain_last");
      tick();
      show("empty");
      chk("empty_vld",    32'(bus.oEptyAddrVld), 0);
      chk("empty_free",   32'(bus.oFreeCnt),     0);
      chk("empty_rlsrdy", 32'(bus.oRlsRdy),      1);
      tick();
      chk("empty_vld2",   32'(bus.oEptyAddrVld), 0);

      // Release 0x123 into empty pool: no bypass, offered one edge later
      bus.iRlsAddr = 12'h123;
      bus.iRlsVld  = 1'b1;
      tick();
      bus.iRlsVld  = 1'b0;
      show("rls_accept");
      chk("rls_vld_k",  32'(bus.oEptyAddrVld), 0);
      chk("rls_free_k", 32'(bus.oFreeCnt),     1);
      tick();
      show("rls_grant");
      chk("rls_vld",  32'(bus.oEptyAddrVld), 32'h2000);
      chk("rls_addr", 32'(bus.oEptyAddr),    32'h123);
      chk("rls_free", 32'(bus.oFreeCnt),     1);

      // Refill pool to 100 with the stage held, then push and pop together
      bus.iEptyAddrRcvRdy = 16'h0000;
      for (int j = 0; j < 100; j++) begin
         bus.iRlsAddr = 12'(32'h200 + j);
         bus.iRlsVld  = 1'b1;
         tick();
      end
      bus.iRlsVld = 1'b0;
      show("refill");
      chk("refill_free", 32'(bus.oFreeCnt),  101);
      chk("refill_addr", 32'(bus.oEptyAddr), 32'h123);
      bus.iEptyAddrRcvRdy = 16'h2000;
      bus.iRlsVld         = 1'b1;
      bus.iRlsAddr        = 12'h300;
      tick();
      bus.iRlsVld = 1'b0;
      show("push_pop");
      chk("pp_vld",  32'(bus.oEptyAddrVld), 32'h2000);
      chk("pp_addr", 32'(bus.oEptyAddr),    32'h200);
      chk("pp_free", 32'(bus.oFreeCnt),     101);
      tick();
      show("stream");
      chk("st_addr", 32'(bus.oEptyAddr), 32'h201);
      chk("st_free", 32'(bus.oFreeCnt),  100);

      // Mid-stream reset: outputs clear at once, init reruns, first grant is 0
      rst_n = 1'b0;
      #1;
      show("mid_reset");
      chk("mr_vld",      32'(bus.oEptyAddrVld), 0);
      chk("mr_addr",     32'(bus.oEptyAddr),    0);
      chk("mr_free",     32'(bus.oFreeCnt),     0);
      chk("mr_rlsrdy",   32'(bus.oRlsRdy),      0);
      chk("mr_initdone", 32'(bus.oInitDone),    0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n = 0;
      while (!bus.oInitDone && n < 5000) begin
         tick();
         n++;
      end
      chk("reinit_edges", 32'(n), 4096);
      chk("reinit_vld",   32'(bus.oEptyAddrVld), 0);
      tick();
      show("reinit_grant");
      chk("reinit_gvld",  32'(bus.oEptyAddrVld), 32'h2000);
      chk("reinit_addr",  32'(bus.oEptyAddr),    0);
      chk("reinit_free",  32'(bus.oFreeCnt),     4096);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
